// File: rtl/snn_cfg_pkg.sv
// Shared types and register map for the SNN configuration sequencer.
package snn_cfg_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        CHK    = 3'd2,
        COMMIT = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    // Network register map.
    localparam int ADDR_THRESHOLD = 0;
    localparam int ADDR_LEAK      = 1;
    localparam int ADDR_REFRAC    = 2;
    localparam int ADDR_W1_BASE   = 3;
    localparam int ADDR_W2_BASE   = 6;
    localparam int NUM_REGS       = 15;

endpackage

// File: rtl/snn_cfg_sequencer_if.sv
// Byte-stream, config-write and spike-gate signals between pin I/O and the sequencer.
interface snn_cfg_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int N_IN   = 3
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_we;
    logic [N_IN-1:0]   spikes_req;
    logic [N_IN-1:0]   spikes_gated;
    logic              busy;
    logic              done;
    logic              err;

    // Pin-side driver of the byte stream and raw spikes.
    modport master (
        output in_valid, in_data, spikes_req,
        input  in_ready, cfg_addr, cfg_data, cfg_we, spikes_gated, busy, done, err
    );

    // The sequencer itself.
    modport slave (
        input  in_valid, in_data, spikes_req,
        output in_ready, cfg_addr, cfg_data, cfg_we, spikes_gated, busy, done, err
    );
endinterface

// File: rtl/snn_cfg_buffer.sv
// One-frame byte buffer: sequential write pointer, rewindable read pointer, registered read.
module snn_cfg_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 15,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_rewind,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr_reg;
    logic [PTR_W-1:0]  rptr_reg;
    logic [PTR_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data_reg;
    logic              wr_ok;

    // Never write past the last entry, even on a malformed stream.
    assign wr_ok   = wr_en && (wptr_reg < PTR_W'(DEPTH));
    // Rewind restarts the read at entry 0 in the same cycle.
    assign rd_addr = rd_rewind ? '0 : rptr_reg;
    assign rd_data = rd_data_reg;

    // Storage array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr_reg] <= wr_data;
        end
    end

    // Write pointer: restarts on clear so a new frame overwrites the old one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_reg <= '0;
        end else if (clear) begin
            wptr_reg <= '0;
        end else if (wr_ok) begin
            wptr_reg <= wptr_reg + 1'b1;
        end
    end

    // Registered read port and read pointer advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_reg    <= '0;
            rd_data_reg <= '0;
        end else if (clear) begin
            rptr_reg    <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
            rptr_reg    <= rd_addr + 1'b1;
        end
    end
endmodule

// File: rtl/snn_cfg_sequencer.sv
// Frame-based configuration loader: buffers HDR/DATA/CHK frames, verifies the XOR
// checksum, then replays the bytes as consecutive register writes with spikes gated.
module snn_cfg_sequencer #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = snn_cfg_pkg::NUM_REGS,
    parameter int N_IN     = 3
) (
    input logic                clk,
    input logic                reset,
    snn_cfg_sequencer_if.slave bus
);
    import snn_cfg_pkg::*;

    state_t              state_reg, state_next;
    logic                accept;
    logic                in_ready;
    logic [ADDR_W-1:0]   hdr_start;
    logic [ADDR_W-1:0]   hdr_cnt_m1;
    logic [ADDR_W:0]     hdr_span;
    logic                hdr_ok;
    logic                chk_match;
    logic                last_data;
    logic                last_write;

    logic [ADDR_W-1:0]   start_reg;
    logic [ADDR_W-1:0]   cnt_m1_reg;
    logic [ADDR_W-1:0]   cnt_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic [ADDR_W:0]     drain_reg;
    logic [DATA_W-1:0]   chk_reg;
    logic                err_reg;

    logic                cfg_we_reg, cfg_we_next;
    logic [ADDR_W-1:0]   cfg_addr_reg, cfg_addr_next;
    logic                done_reg, done_next;

    logic                buf_clear;
    logic                buf_wr;
    logic                buf_rd;
    logic                buf_rewind;
    logic [DATA_W-1:0]   buf_rd_data;
    logic                gate;

    // Header fields; the span is widened by one bit so start+cnt_m1 cannot wrap.
    assign hdr_start  = bus.in_data[DATA_W-1 -: ADDR_W];
    assign hdr_cnt_m1 = bus.in_data[ADDR_W-1:0];
    assign hdr_span   = {1'b0, hdr_start} + {1'b0, hdr_cnt_m1};
    assign hdr_ok     = (hdr_span <= (ADDR_W+1)'(NUM_REGS - 1));

    assign in_ready   = (state_reg != COMMIT);
    assign accept     = bus.in_valid && in_ready;
    assign chk_match  = (bus.in_data == chk_reg);
    assign last_data  = (cnt_reg == cnt_m1_reg);
    assign last_write = (idx_reg == cnt_m1_reg);
    assign gate       = (state_reg == COMMIT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = hdr_ok ? DATA : DRAIN;
            DATA:    if (accept && last_data) state_next = CHK;
            CHK:     if (accept) state_next = chk_match ? COMMIT : IDLE;
            COMMIT:  if (last_write) state_next = IDLE;
            DRAIN:   if (accept && (drain_reg == (ADDR_W+1)'(1))) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and buffer-control decode; write outputs are registered below.
    always_comb begin
        cfg_we_next   = 1'b0;
        cfg_addr_next = cfg_addr_reg;
        done_next     = 1'b0;
        buf_clear     = 1'b0;
        buf_wr        = 1'b0;
        buf_rd        = 1'b0;
        buf_rewind    = 1'b0;
        case (state_reg)
            IDLE: begin
                buf_clear = accept && hdr_ok;
            end
            DATA: begin
                buf_wr = accept;
            end
            CHK: begin
                // Issue the first write the cycle after the checksum is accepted.
                if (accept && chk_match) begin
                    cfg_we_next   = 1'b1;
                    cfg_addr_next = start_reg;
                    buf_rd        = 1'b1;
                    buf_rewind    = 1'b1;
                end
            end
            COMMIT: begin
                if (last_write) begin
                    done_next = 1'b1;
                end else begin
                    cfg_we_next   = 1'b1;
                    cfg_addr_next = cfg_addr_reg + 1'b1;
                    buf_rd        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered write/done outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_we_reg   <= 1'b0;
            cfg_addr_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            cfg_we_reg   <= cfg_we_next;
            cfg_addr_reg <= cfg_addr_next;
            done_reg     <= done_next;
        end
    end

    // Frame bookkeeping: header fields, byte counters, running checksum, sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_reg  <= '0;
            cnt_m1_reg <= '0;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            drain_reg  <= '0;
            chk_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        err_reg    <= !hdr_ok;
                        chk_reg    <= bus.in_data;
                        start_reg  <= hdr_start;
                        cnt_m1_reg <= hdr_cnt_m1;
                        cnt_reg    <= '0;
                        // A rejected frame still carries cnt data bytes plus CHK.
                        drain_reg  <= {1'b0, hdr_cnt_m1} + (ADDR_W+1)'(2);
                    end
                end
                DATA: begin
                    if (accept) begin
                        chk_reg <= chk_reg ^ bus.in_data;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CHK: begin
                    idx_reg <= '0;
                    if (accept && !chk_match) begin
                        err_reg <= 1'b1;
                    end
                end
                COMMIT: begin
                    idx_reg <= idx_reg + 1'b1;
                end
                DRAIN: begin
                    if (accept) begin
                        drain_reg <= drain_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    snn_cfg_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (NUM_REGS),
        .PTR_W  (ADDR_W)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .clear     (buf_clear),
        .wr_en     (buf_wr),
        .wr_data   (bus.in_data),
        .rd_en     (buf_rd),
        .rd_rewind (buf_rewind),
        .rd_data   (buf_rd_data)
    );

    // Spikes are held off for the whole commit so no half-written parameters are integrated.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_gate
            assign bus.spikes_gated[gi] = bus.spikes_req[gi] & ~gate;
        end
    endgenerate

    assign bus.in_ready = in_ready;
    assign bus.cfg_we   = cfg_we_reg;
    assign bus.cfg_addr = cfg_addr_reg;
    assign bus.cfg_data = buf_rd_data;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = done_reg;
    assign bus.err      = err_reg;
endmodule

// File: tb/tb_snn_cfg_sequencer.sv
// Self-checking bench for snn_cfg_sequencer: directed frames plus randomized frames
// with random valid gaps, checked against a frame-level reference model.
module tb_snn_cfg_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    snn_cfg_sequencer_if #(.ADDR_W(4), .DATA_W(8), .N_IN(3)) bus ();

    snn_cfg_sequencer #(
        .ADDR_W   (4),
        .DATA_W   (8),
        .NUM_REGS (15),
        .N_IN     (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef logic [7:0] frame_t [$];

    int          errors = 0;
    int          checks = 0;
    logic [11:0] exp_wr [$];
    int          exp_done = 0;
    int          done_seen = 0;
    int          extra_wr = 0;
    logic        exp_err = 1'b0;
    bit          gaps = 1'b0;
    logic [11:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // Write monitor: every cfg_we must match the next expected write with spikes gated.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cfg_we === 1'b1) begin
                check("gate", 32'(bus.spikes_gated), 32'd0);
                if (exp_wr.size() == 0) begin
                    extra_wr++;
                end else begin
                    mon_exp = exp_wr.pop_front();
                    check("wr", 32'({bus.cfg_addr, bus.cfg_data}), 32'(mon_exp));
                end
            end
            if (bus.done === 1'b1) done_seen++;
        end
    end

    // Frame-level reference: decides outcome from header range and XOR checksum.
    task automatic model_frame(input frame_t f);
        int         start;
        int         cm1;
        logic [7:0] x;
        start = int'(f[0][7:4]);
        cm1   = int'(f[0][3:0]);
        if (start + cm1 > 14) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i <= cm1 + 1; i++) x = x ^ f[i];
        if (x != f[cm1 + 2]) begin
            exp_err = 1'b1;
            return;
        end
        exp_err = 1'b0;
        for (int i = 0; i <= cm1; i++) exp_wr.push_back({4'(start + i), f[i + 1]});
        exp_done++;
    endtask

    // Present one byte from a negedge; returns at the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) check("ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        if (gaps) bus.spikes_req = 3'($urandom);
    endtask

    task automatic send_frame(input frame_t f);
        model_frame(f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    function automatic frame_t rand_frame();
        frame_t     f;
        int         kind;
        int         start;
        int         cm1;
        logic [7:0] x;
        kind = $urandom_range(0, 9);
        if (kind < 2) begin
            start = $urandom_range(0, 15);
            cm1   = $urandom_range(0, 15);
        end else begin
            start = $urandom_range(0, 14);
            cm1   = $urandom_range(0, 14 - start);
        end
        f.push_back({4'(start), 4'(cm1)});
        if (start + cm1 > 14) begin
            for (int i = 0; i < cm1 + 2; i++) f.push_back(8'($urandom));
        end else begin
            x = f[0];
            for (int i = 0; i <= cm1; i++) begin
                f.push_back(8'($urandom));
                x = x ^ f[i + 1];
            end
            if (kind == 2) x = x ^ (8'h01 << $urandom_range(0, 7));
            f.push_back(x);
        end
        return f;
    endfunction

    initial begin
        frame_t f;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.spikes_req = 3'b000;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_err",   32'(bus.err),      32'd0);
        check("rst_we",    32'(bus.cfg_we),   32'd0);
        check("rst_addr",  32'(bus.cfg_addr), 32'd0);
        check("rst_data",  32'(bus.cfg_data), 32'd0);
        check("rst_done",  32'(bus.done),     32'd0);

        // Bad checksum: error, no writes, straight back to IDLE.
        f = '{8'h10, 8'hAA, 8'h00};
        send_frame(f);
        check("badchk_busy", 32'(bus.busy), 32'd0);
        check("badchk_err",  32'(bus.err),  32'(exp_err));

        // Good 3-byte frame with exact latency; header clears the sticky error.
        bus.spikes_req = 3'b111;
        f = '{8'h02, 8'h40, 8'h05, 8'h10, 8'h57};
        model_frame(f);
        send_byte(f[0]);
        check("hdr_clr_err", 32'(bus.err), 32'd0);
        for (int i = 1; i < 5; i++) send_byte(f[i]);
        for (int i = 0; i < 3; i++) begin
            check("t2_we",   32'(bus.cfg_we),       32'd1);
            check("t2_gate", 32'(bus.spikes_gated), 32'd0);
            @(negedge clk);
        end
        check("t2_done",    32'(bus.done),         32'd1);
        check("t2_done_we", 32'(bus.cfg_we),       32'd0);
        @(negedge clk);
        check("t2_done_1",  32'(bus.done),         32'd0);
        check("t2_spikes",  32'(bus.spikes_gated), 32'd7);
        check("t2_err",     32'(bus.err),          32'(exp_err));

        // Error set again, then reset mid-DATA: aborted, nothing written.
        f = '{8'h10, 8'hAA, 8'h00};
        send_frame(f);
        send_byte(8'h22);
        send_byte(8'h11);
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_ready", 32'(bus.in_ready), 32'd1);
        check("arst_busy",  32'(bus.busy),     32'd0);
        check("arst_err",   32'(bus.err),      32'd0);
        @(negedge clk);
        reset   = 1'b0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_we", 32'(bus.cfg_we), 32'd0);

        // Bad header: start 14 + 2 bytes, drains exactly 3 bytes.
        f = '{8'hE1, 8'h33, 8'h44, 8'h55};
        send_frame(f);
        check("badhdr_busy", 32'(bus.busy), 32'd0);
        check("badhdr_err",  32'(bus.err),  32'(exp_err));

        // Edge frame at the last register.
        f = '{8'hE0, 8'h7F, 8'h9F};
        send_frame(f);
        wait_idle();
        check("edge_err", 32'(bus.err), 32'(exp_err));

        // cnt_m1=15 is always rejected and drains 17 bytes.
        f = '{8'h0F};
        for (int i = 0; i < 17; i++) f.push_back(8'($urandom));
        send_frame(f);
        check("cnt16_busy", 32'(bus.busy), 32'd0);
        check("cnt16_err",  32'(bus.err),  32'(exp_err));

        // Random frames with random valid gaps, then back-to-back.
        gaps = 1'b1;
        for (int k = 0; k < 30; k++) send_frame(rand_frame());
        gaps = 1'b0;
        for (int k = 0; k < 15; k++) send_frame(rand_frame());
        wait_idle();
        check("rand_err",      32'(bus.err),        32'(exp_err));
        check("wr_pending",    32'(exp_wr.size()),  32'd0);
        check("wr_extra",      32'(extra_wr),       32'd0);
        check("done_count",    32'(done_seen),      32'(exp_done));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
